// File: rtl/vga_tile_scheduler_if.sv
// Requester, glyph-lookup and vga_adapter signals of the tile scheduler.
// slave: scheduler side; master: requesters, lookup and display side.
interface vga_tile_scheduler_if;
  logic       req_a;
  logic [3:0] col_a;
  logic [2:0] row_a;
  logic [4:0] val_a;
  logic       ack_a;
  logic       req_b;
  logic [3:0] col_b;
  logic [2:0] row_b;
  logic [4:0] val_b;
  logic       ack_b;
  logic [4:0] glyph_val;
  logic [3:0] glyph_u;
  logic [3:0] glyph_v;
  logic       glyph_on;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       busy;
  logic       err;

  modport slave (
    input  req_a, col_a, row_a, val_a,
    input  req_b, col_b, row_b, val_b,
    input  glyph_on,
    output ack_a, ack_b,
    output glyph_val, glyph_u, glyph_v,
    output x, y, colour, plot,
    output busy, err
  );

  modport master (
    output req_a, col_a, row_a, val_a,
    output req_b, col_b, row_b, val_b,
    output glyph_on,
    input  ack_a, ack_b,
    input  glyph_val, glyph_u, glyph_v,
    input  x, y, colour, plot,
    input  busy, err
  );
endinterface

// File: rtl/vga_tile_scheduler.sv
// Round-robin glyph tile drawer: grants A/B, sweeps 16x16 pixels of a
// 10x7 tile grid, queries the glyph lookup, drives vga_adapter x/y/colour/plot.
// Ports: clk, reset (sync, active-high), bus (vga_tile_scheduler_if.slave).
module vga_tile_scheduler #(
  parameter logic [2:0] FG_COLOUR = 3'b000,
  parameter logic [2:0] BG_COLOUR = 3'b111,
  parameter logic [4:0] CLEAR_VAL = 5'd31
) (
  input logic                 clk,
  input logic                 reset,
  vga_tile_scheduler_if.slave bus
);

  typedef enum logic {IDLE, DRAW} state_e;

  state_e     state_q, state_d;
  logic       last_b_q, last_b_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] col_q, col_d;
  logic [2:0] row_q, row_d;
  logic [4:0] val_q, val_d;
  logic       ack_a_q, ack_a_d;
  logic       ack_b_q, ack_b_d;
  logic       err_q, err_d;
  logic [7:0] x_q, x_d;
  logic [6:0] y_q, y_d;
  logic [2:0] colour_q, colour_d;
  logic       plot_q, plot_d;
  logic [7:0] uv_q, uv_d;
  logic [4:0] gval_q, gval_d;

  logic       gnt_a, gnt_b;
  logic [3:0] gcol;
  logic [2:0] grow;
  logic [4:0] gval;
  logic       in_range;
  logic       draw;

  // last_b_q set means B won the previous grant, so A wins a tie.
  assign gnt_a    = bus.req_a & (~bus.req_b | last_b_q);
  assign gnt_b    = bus.req_b & ~gnt_a;
  assign gcol     = gnt_a ? bus.col_a : bus.col_b;
  assign grow     = gnt_a ? bus.row_a : bus.row_b;
  assign gval     = gnt_a ? bus.val_a : bus.val_b;
  assign in_range = (gcol <= 4'd9) && (grow <= 3'd6);
  assign draw     = (state_q == DRAW);

  always_comb begin
    state_d  = state_q;
    last_b_d = last_b_q;
    cnt_d    = cnt_q;
    col_d    = col_q;
    row_d    = row_q;
    val_d    = val_q;
    ack_a_d  = 1'b0;
    ack_b_d  = 1'b0;
    err_d    = 1'b0;
    x_d      = x_q;
    y_d      = y_q;
    colour_d = colour_q;
    plot_d   = 1'b0;
    uv_d     = uv_q;
    gval_d   = gval_q;
    case (state_q)
      IDLE: begin
        if (gnt_a | gnt_b) begin
          col_d    = gcol;
          row_d    = grow;
          val_d    = gval;
          ack_a_d  = gnt_a;
          ack_b_d  = gnt_b;
          last_b_d = gnt_b;
          if (in_range) begin
            state_d = DRAW;
            cnt_d   = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      DRAW: begin
        // col*16+u and row*16+v are plain bit concatenations.
        x_d    = {col_q, cnt_q[3:0]};
        y_d    = {row_q, cnt_q[7:4]};
        colour_d = (bus.glyph_on && val_q != CLEAR_VAL)
                   ? FG_COLOUR : BG_COLOUR;
        plot_d = 1'b1;
        cnt_d  = cnt_q + 8'd1;
        uv_d   = cnt_q;
        gval_d = val_q;
        if (cnt_q == 8'hff) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      last_b_q <= 1'b1;
      cnt_q    <= '0;
      col_q    <= '0;
      row_q    <= '0;
      val_q    <= '0;
      ack_a_q  <= 1'b0;
      ack_b_q  <= 1'b0;
      err_q    <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= BG_COLOUR;
      plot_q   <= 1'b0;
      uv_q     <= '0;
      gval_q   <= '0;
    end else begin
      state_q  <= state_d;
      last_b_q <= last_b_d;
      cnt_q    <= cnt_d;
      col_q    <= col_d;
      row_q    <= row_d;
      val_q    <= val_d;
      ack_a_q  <= ack_a_d;
      ack_b_q  <= ack_b_d;
      err_q    <= err_d;
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= colour_d;
      plot_q   <= plot_d;
      uv_q     <= uv_d;
      gval_q   <= gval_d;
    end
  end

  // Lookup address follows the counter in DRAW, else holds the last one.
  assign bus.glyph_u   = draw ? cnt_q[3:0] : uv_q[3:0];
  assign bus.glyph_v   = draw ? cnt_q[7:4] : uv_q[7:4];
  assign bus.glyph_val = draw ? val_q : gval_q;
  assign bus.ack_a     = ack_a_q;
  assign bus.ack_b     = ack_b_q;
  assign bus.err       = err_q;
  assign bus.x         = x_q;
  assign bus.y         = y_q;
  assign bus.colour    = colour_q;
  assign bus.plot      = plot_q;
  assign bus.busy      = draw;

endmodule

// File: tb/tb_vga_tile_scheduler.sv
// Self-checking bench for vga_tile_scheduler against a pixel-list model.
// Ports: none (top-level bench).
module tb_vga_tile_scheduler;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vga_tile_scheduler_if bus();
  vga_tile_scheduler dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int failures = 0;
  logic [31:0] cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [255:0] pat [32];
  assign bus.glyph_on = pat[bus.glyph_val][{bus.glyph_v, bus.glyph_u}];

  typedef struct packed {
    logic [31:0] cyc; logic [7:0] x; logic [6:0] y; logic [2:0] c;
  } px_t;
  typedef struct packed {
    logic [31:0] cyc; logic a; logic b; logic e;
  } ack_t;

  px_t  pxq[$];
  ack_t ackq[$];
  logic [7:0] uvq[$];
  int busy_n = 0;
  int err_n = 0;
  bit hold_a = 0;
  bit hold_b = 0;

  always @(negedge clk) begin
    if (bus.plot) pxq.push_back('{cyc, bus.x, bus.y, bus.colour});
    if (bus.ack_a | bus.ack_b)
      ackq.push_back('{cyc, bus.ack_a, bus.ack_b, bus.err});
    if (bus.busy) begin
      uvq.push_back({bus.glyph_v, bus.glyph_u});
      busy_n++;
    end
    if (bus.err) err_n++;
  end

  // Reference: pixel i of a tile in u-fast order.
  function automatic logic [17:0] exp_px(input int c, input int r,
                                         input int v, input int i);
    int u, w;
    logic [7:0] ex; logic [6:0] ey; logic [2:0] ec;
    u = i % 16;
    w = i / 16;
    ex = 8'(c * 16 + u);
    ey = 7'(r * 16 + w);
    ec = (v != 31 && pat[v][w * 16 + u]) ? 3'b000 : 3'b111;
    return {ex, ey, ec};
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
    if (bus.ack_a && !hold_a) bus.req_a = 1'b0;
    if (bus.ack_b && !hold_b) bus.req_b = 1'b0;
  endtask

  task automatic issue(input bit b, input logic [3:0] c,
                       input logic [2:0] r, input logic [4:0] v);
    if (!b) begin
      bus.col_a = c; bus.row_a = r; bus.val_a = v; bus.req_a = 1'b1;
    end else begin
      bus.col_b = c; bus.row_b = r; bus.val_b = v; bus.req_b = 1'b1;
    end
  endtask

  task automatic rand_pat(input int v);
    for (int k = 0; k < 8; k++) pat[v][k * 32 +: 32] = $urandom();
  endtask

  task automatic test_reset();
    bus.req_a = 0; bus.col_a = 0; bus.row_a = 0; bus.val_a = 0;
    bus.req_b = 0; bus.col_b = 0; bus.row_b = 0; bus.val_b = 0;
    reset = 1'b1;
    repeat (3) step();
    checks++;
    if ({bus.x, bus.y} !== 15'd0) begin
      failures++; $display("FAIL reset_xy got=%h exp=0", {bus.x, bus.y});
    end
    checks++;
    if (bus.colour !== 3'b111) begin
      failures++; $display("FAIL reset_colour got=%b exp=111", bus.colour);
    end
    checks++;
    if ({bus.plot, bus.busy, bus.ack_a, bus.ack_b, bus.err} !== 5'd0) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=00000",
               {bus.plot, bus.busy, bus.ack_a, bus.ack_b, bus.err});
    end
    checks++;
    if ({bus.glyph_u, bus.glyph_v, bus.glyph_val} !== 13'd0) begin
      failures++;
      $display("FAIL reset_glyph got=%h exp=0",
               {bus.glyph_u, bus.glyph_v, bus.glyph_val});
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_single_tile();
    int p0, a0, b0, t, n;
    pat[7] = '1;
    p0 = pxq.size(); a0 = ackq.size(); b0 = busy_n;
    t = int'(cyc);
    issue(0, 4'd4, 3'd3, 5'd7);
    repeat (270) step();
    checks++;
    if (ackq.size() - a0 != 1) begin
      failures++; $display("FAIL single_acks got=%0d exp=1", ackq.size() - a0);
    end else begin
      checks++;
      if (ackq[a0] !== ack_t'({32'(t + 1), 1'b1, 1'b0, 1'b0})) begin
        failures++;
        $display("FAIL single_ack got=%h exp_cyc=%0d a=1 b=0 e=0",
                 ackq[a0], t + 1);
      end
    end
    n = pxq.size() - p0;
    checks++;
    if (n != 256) begin
      failures++; $display("FAIL single_count got=%0d exp=256", n);
    end
    for (int i = 0; i < (n < 256 ? n : 256); i++) begin
      px_t p; logic [17:0] e;
      p = pxq[p0 + i]; e = exp_px(4, 3, 7, i);
      checks++;
      if ({p.x, p.y, p.c} !== e || p.cyc !== 32'(t + 2 + i)) begin
        failures++;
        if (failures < 30)
          $display("FAIL single_px i=%0d got=%h@%0d exp=%h@%0d",
                   i, {p.x, p.y, p.c}, p.cyc, e, t + 2 + i);
      end
    end
    checks++;
    if (busy_n - b0 != 256) begin
      failures++; $display("FAIL single_busy got=%0d exp=256", busy_n - b0);
    end
  endtask

  task automatic test_clear_tile();
    int p0, u0, n;
    pat[31] = '1;
    p0 = pxq.size(); u0 = uvq.size();
    issue(0, 4'd2, 3'd1, 5'd31);
    repeat (270) step();
    n = pxq.size() - p0;
    checks++;
    if (n != 256 || uvq.size() - u0 != 256) begin
      failures++;
      $display("FAIL clear_count got=%0d/%0d exp=256/256", n, uvq.size() - u0);
    end else begin
      for (int i = 0; i < 256; i++) begin
        checks++;
        if (pxq[p0 + i].c !== 3'b111 || uvq[u0 + i] !== 8'(i)) begin
          failures++;
          if (failures < 30)
            $display("FAIL clear_px i=%0d got=%b uv=%h exp=111 uv=%h",
                     i, pxq[p0 + i].c, uvq[u0 + i], 8'(i));
        end
      end
    end
  endtask

  task automatic test_tie();
    int p0, a0, t, n;
    int fc[2], fr[2], fv[2];
    reset = 1'b1; step(); step(); reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      fc[k] = int'($urandom_range(9));
      fr[k] = int'($urandom_range(6));
      fv[k] = int'($urandom_range(30));
      rand_pat(fv[k]);
    end
    p0 = pxq.size(); a0 = ackq.size();
    hold_a = 1; hold_b = 1;
    t = int'(cyc);
    issue(0, 4'(fc[0]), 3'(fr[0]), 5'(fv[0]));
    issue(1, 4'(fc[1]), 3'(fr[1]), 5'(fv[1]));
    for (int k = 0; k < 1100 && ackq.size() - a0 < 4; k++) step();
    bus.req_a = 0; bus.req_b = 0;
    hold_a = 0; hold_b = 0;
    repeat (270) step();
    checks++;
    if (ackq.size() - a0 != 4) begin
      failures++; $display("FAIL tie_acks got=%0d exp=4", ackq.size() - a0);
    end else begin
      for (int k = 0; k < 4; k++) begin
        ack_t ea;
        ea = '{32'(t + 1 + 257 * k), (k % 2 == 0), (k % 2 == 1), 1'b0};
        checks++;
        if (ackq[a0 + k] !== ea) begin
          failures++;
          $display("FAIL tie_ack k=%0d got=%h exp=%h", k, ackq[a0 + k], ea);
        end
      end
    end
    n = pxq.size() - p0;
    checks++;
    if (n != 1024) begin
      failures++; $display("FAIL tie_count got=%0d exp=1024", n);
    end else begin
      for (int j = 0; j < 1024; j++) begin
        px_t p; logic [17:0] e; int k, i, tc;
        k = j / 256; i = j % 256;
        p = pxq[p0 + j];
        e = exp_px(fc[k % 2], fr[k % 2], fv[k % 2], i);
        tc = t + 2 + 257 * k + i;
        checks++;
        if ({p.x, p.y, p.c} !== e || p.cyc !== 32'(tc)) begin
          failures++;
          if (failures < 30)
            $display("FAIL tie_px j=%0d got=%h@%0d exp=%h@%0d",
                     j, {p.x, p.y, p.c}, p.cyc, e, tc);
        end
      end
    end
  endtask

  task automatic test_out_of_range();
    int p0, a0, b0, e0, t, n, c, r, v;
    p0 = pxq.size(); a0 = ackq.size(); b0 = busy_n; e0 = err_n;
    issue(1, 4'd10, 3'd0, 5'd5);
    repeat (3) step();
    issue(1, 4'd0, 3'd7, 5'd5);
    repeat (3) step();
    checks++;
    if (ackq.size() - a0 != 2) begin
      failures++; $display("FAIL oor_acks got=%0d exp=2", ackq.size() - a0);
    end else begin
      for (int k = 0; k < 2; k++) begin
        checks++;
        if ({ackq[a0 + k].a, ackq[a0 + k].b, ackq[a0 + k].e} !== 3'b011) begin
          failures++;
          $display("FAIL oor_ack_err k=%0d got=%b exp=011", k,
                   {ackq[a0 + k].a, ackq[a0 + k].b, ackq[a0 + k].e});
        end
      end
    end
    checks++;
    if (err_n - e0 != 2 || pxq.size() != p0 || busy_n != b0) begin
      failures++;
      $display("FAIL oor_quiet got=err%0d plot%0d busy%0d exp=2/0/0",
               err_n - e0, pxq.size() - p0, busy_n - b0);
    end
    c = int'($urandom_range(9)); r = int'($urandom_range(6));
    v = int'($urandom_range(30)); rand_pat(v);
    a0 = ackq.size(); p0 = pxq.size();
    t = int'(cyc);
    issue(1, 4'(c), 3'(r), 5'(v));
    repeat (270) step();
    checks++;
    if (ackq.size() - a0 != 1 || err_n - e0 != 2) begin
      failures++;
      $display("FAIL oor_next_ack got=%0d err=%0d exp=1/2",
               ackq.size() - a0, err_n - e0);
    end else begin
      checks++;
      if (ackq[a0] !== ack_t'({32'(t + 1), 1'b0, 1'b1, 1'b0})) begin
        failures++;
        $display("FAIL oor_next_ackv got=%h exp_cyc=%0d", ackq[a0], t + 1);
      end
    end
    n = pxq.size() - p0;
    checks++;
    if (n != 256) begin
      failures++; $display("FAIL oor_next_count got=%0d exp=256", n);
    end
    for (int i = 0; i < (n < 256 ? n : 256); i++) begin
      logic [17:0] e;
      e = exp_px(c, r, v, i);
      checks++;
      if ({pxq[p0 + i].x, pxq[p0 + i].y, pxq[p0 + i].c} !== e) begin
        failures++;
        if (failures < 30)
          $display("FAIL oor_next_px i=%0d got=%h exp=%h", i,
                   {pxq[p0 + i].x, pxq[p0 + i].y, pxq[p0 + i].c}, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    int p0, a0;
    rand_pat(9);
    p0 = pxq.size();
    issue(0, 4'd5, 3'd2, 5'd9);
    for (int k = 0; k < 200 && pxq.size() - p0 < 100; k++) step();
    reset = 1'b1;
    step();
    checks++;
    if ({bus.x, bus.y, bus.colour, bus.plot, bus.busy, bus.ack_a,
         bus.ack_b, bus.err} !== {8'd0, 7'd0, 3'b111, 5'd0}) begin
      failures++;
      $display("FAIL mid_reset_out got=%h exp=%h",
               {bus.x, bus.y, bus.colour, bus.plot, bus.busy, bus.ack_a,
                bus.ack_b, bus.err}, {8'd0, 7'd0, 3'b111, 5'd0});
    end
    checks++;
    if ({bus.glyph_u, bus.glyph_v, bus.glyph_val} !== 13'd0) begin
      failures++;
      $display("FAIL mid_reset_glyph got=%h exp=0",
               {bus.glyph_u, bus.glyph_v, bus.glyph_val});
    end
    checks++;
    if (pxq.size() - p0 != 100) begin
      failures++; $display("FAIL mid_partial got=%0d exp=100", pxq.size() - p0);
    end
    reset = 1'b0;
    a0 = ackq.size(); p0 = pxq.size();
    issue(0, 4'd1, 3'd1, 5'd9);
    issue(1, 4'd2, 3'd2, 5'd9);
    for (int k = 0; k < 10 && ackq.size() == a0; k++) step();
    bus.req_b = 0;
    bus.req_a = 0;
    repeat (270) step();
    checks++;
    if (ackq.size() - a0 != 1) begin
      failures++; $display("FAIL mid_tie_acks got=%0d exp=1", ackq.size() - a0);
    end else begin
      checks++;
      if ({ackq[a0].a, ackq[a0].b} !== 2'b10) begin
        failures++;
        $display("FAIL mid_tie_grant got=%b exp=10",
                 {ackq[a0].a, ackq[a0].b});
      end
    end
    checks++;
    if (pxq.size() - p0 != 256) begin
      failures++; $display("FAIL mid_tile_count got=%0d exp=256", pxq.size() - p0);
    end
  endtask

  task automatic test_glyph_pattern();
    int p0, n, fg, mx, my, v;
    v = int'($urandom_range(30));
    pat[v] = '0;
    for (int i = 0; i < 16; i++) pat[v][i * 17] = 1'b1;
    p0 = pxq.size();
    issue(1, 4'd9, 3'd6, 5'(v));
    repeat (270) step();
    n = pxq.size() - p0;
    fg = 0; mx = 0; my = 0;
    checks++;
    if (n != 256) begin
      failures++; $display("FAIL diag_count got=%0d exp=256", n);
    end
    for (int i = 0; i < (n < 256 ? n : 256); i++) begin
      px_t p; logic [17:0] e;
      p = pxq[p0 + i]; e = exp_px(9, 6, v, i);
      if (p.c == 3'b000) fg++;
      if (int'(p.x) > mx) mx = int'(p.x);
      if (int'(p.y) > my) my = int'(p.y);
      checks++;
      if ({p.x, p.y, p.c} !== e) begin
        failures++;
        if (failures < 30)
          $display("FAIL diag_px i=%0d got=%h exp=%h", i, {p.x, p.y, p.c}, e);
      end
    end
    checks++;
    if (fg != 16 || mx != 159 || my != 111) begin
      failures++;
      $display("FAIL diag_extent got=fg%0d x%0d y%0d exp=16/159/111",
               fg, mx, my);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 5; it++) begin
      int p0, a0, n, c, r, v;
      bit b;
      b = 1'($urandom_range(1));
      c = int'($urandom_range(9)); r = int'($urandom_range(6));
      v = ($urandom_range(3) == 0) ? 31 : int'($urandom_range(30));
      rand_pat(v);
      p0 = pxq.size(); a0 = ackq.size();
      issue(b, 4'(c), 3'(r), 5'(v));
      repeat (262) step();
      checks++;
      if (ackq.size() - a0 != 1) begin
        failures++; $display("FAIL rand_acks it=%0d got=%0d exp=1",
                             it, ackq.size() - a0);
      end else begin
        checks++;
        if ({ackq[a0].a, ackq[a0].b, ackq[a0].e} !== {~b, b, 1'b0}) begin
          failures++;
          $display("FAIL rand_grant it=%0d got=%b exp=%b", it,
                   {ackq[a0].a, ackq[a0].b, ackq[a0].e}, {~b, b, 1'b0});
        end
      end
      n = pxq.size() - p0;
      checks++;
      if (n != 256) begin
        failures++; $display("FAIL rand_count it=%0d got=%0d exp=256", it, n);
      end
      for (int i = 0; i < (n < 256 ? n : 256); i++) begin
        logic [17:0] e;
        e = exp_px(c, r, v, i);
        checks++;
        if ({pxq[p0 + i].x, pxq[p0 + i].y, pxq[p0 + i].c} !== e) begin
          failures++;
          if (failures < 30)
            $display("FAIL rand_px it=%0d i=%0d got=%h exp=%h", it, i,
                     {pxq[p0 + i].x, pxq[p0 + i].y, pxq[p0 + i].c}, e);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) pat[i] = '0;
    test_reset();
    test_single_tile();
    test_clear_tile();
    test_tie();
    test_out_of_range();
    test_reset_mid();
    test_glyph_pattern();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vga_tile_scheduler.md
# vga_tile_scheduler

Arbitrating draw controller for the 160x120 VGA pixel path. It accepts glyph draw requests from two requesters, for example the sequence player and the player-input echo. Each request names a glyph value and a 16x16 tile on a 10x7 grid. The block grants requesters round-robin, sweeps the 256 pixels of the granted tile, queries an external glyph lookup per pixel, and drives `x/y/colour/plot` straight into `vga_adapter`.

## Interface
Parameters:
- `FG_COLOUR`, default 3'b000, colour for lit glyph pixels.
- `BG_COLOUR`, default 3'b111, colour for unlit pixels and for clear requests.
- `CLEAR_VAL`, default 5'd31, glyph value that means "fill tile with BG".

Ports (one clock; reset is synchronous and active-high):
- `clk` input 1: system clock (CLOCK_50 domain).
- `reset` input 1: synchronous, active-high.
- `req_a` input 1: requester A draw request, level.
- `col_a` input 4: A tile column.
- `row_a` input 3: A tile row.
- `val_a` input 5: A glyph value.
- `ack_a` output 1: one-cycle grant pulse to A.
- `req_b`, `col_b`, `row_b`, `val_b`, `ack_b`: same as A, for requester B.
- `glyph_val` output 5: latched glyph value to the lookup.
- `glyph_u` output 4: pixel column in the tile, 0-15.
- `glyph_v` output 4: pixel row in the tile, 0-15.
- `glyph_on` input 1: combinational lookup result for (`glyph_val`, `glyph_u`, `glyph_v`).
- `x` output 8: pixel x to `vga_adapter`.
- `y` output 7: pixel y to `vga_adapter`.
- `colour` output 3: pixel colour to `vga_adapter`.
- `plot` output 1: pixel write strobe to `vga_adapter`.
- `busy` output 1: high while in DRAW.
- `err` output 1: one-cycle pulse on an out-of-range grant.

## Operation
- States: IDLE and DRAW. Reset enters IDLE.
- **IDLE, arbitration:** on each edge, if any `req_*` is high, grant one requester.
  - If only one requests, grant it.
  - If both request, grant the one not granted last.
  - The last-grant pointer resets to B, so A wins the first tie.
- **IDLE, on grant:**
  - Latch the granted col/row/val.
  - Pulse the matching `ack_*` (registered, high for one cycle).
  - Update the last-grant pointer.
- **Range check at grant:**
  - If col > 9 or row > 6, pulse `err` together with `ack`, do not enter DRAW, and remain in IDLE.
  - Otherwise enter DRAW with the 8-bit pixel counter `cnt` = 0.
- **DRAW outputs:**
  - `glyph_u` = `cnt[3:0]`, `glyph_v` = `cnt[7:4]`, `glyph_val` = latched val.
  - Outside DRAW these hold their last values.
- **DRAW, each edge:**
  - Register `x` = col*16 + `cnt[3:0]` and `y` = row*16 + `cnt[7:4]`.
  - Register `colour` = FG if (`glyph_on` and val != `CLEAR_VAL`), else BG.
  - Register `plot` = 1 and increment `cnt`.
- **Width rules:**
  - col*16 + u is at most 159, so it fits 8 bits.
  - row*16 + v is at most 111, so it fits 7 bits.
  - No wrap occurs for in-range requests.
- **End of DRAW:** the edge with `cnt` = 255 registers the last pixel and returns to IDLE. `cnt` wraps to 0.
- **Requester protocol:**
  - Fields must stay stable while `req` is high.
  - Drop `req` in the cycle after `ack`. A `req` still high then is treated as a new request.
  - Requests arriving during DRAW wait. Nothing is dropped or queued beyond the level.
- **Reset mid-DRAW:** aborts immediately. The partial tile stays on screen and nothing is cleaned up.

## Timing
- Reset values:
  - `x` = 0, `y` = 0, `colour` = `BG_COLOUR`.
  - `plot` = 0, `busy` = 0, `ack_a` = `ack_b` = 0, `err` = 0.
  - `glyph_u` = `glyph_v` = 0, `glyph_val` = 0.
  - `cnt` = 0, last-grant pointer = B.
- **Request to first plot:** `req` is sampled at edge E0.
  - `ack` and `busy` go high in the cycle after E0.
  - The first `plot` is high after E1.
- **Plot duration:** `plot` is high for exactly 256 consecutive cycles per tile, covering pixels (0,0),(1,0)…(15,0),(0,1)…(15,15) in u-fast order.
- **busy:** high for 256 cycles, falling in the same cycle as the last `plot`.
- **Back-to-back:** with a pending request, the next `ack` follows the last `plot` cycle. There is exactly one `plot` = 0 cycle between tiles (tile period 257 cycles).
- **Out-of-range grant:** occupies one IDLE cycle, with no `plot` and no `busy`.
- **Glyph lookup:** `glyph_on` must settle within the cycle that `glyph_u/v` are presented.

## Test plan
- **Single tile:** reset; `req_a` with col=4, row=3, val=7, `glyph_on` tied 1.
  - `ack_a` pulses once.
  - 256 plots with x 64..79, y 48..63, all `colour` = 000.
  - The first `plot` comes 2 edges after the request edge.
- **Clear tile:** val=31 with `glyph_on` = 1.
  - All 256 pixels get `colour` = 111.
  - `glyph_u/v` still sweep 0..15.
- **Tie arbitration:** `req_a` and `req_b` held continuously.
  - Grants go A, B, A, B.
  - Tiles are separated by exactly one `plot` = 0 cycle, giving a 257-cycle period.
- **Out of range:** `req_b` with col=10, then with row=7.
  - `ack_b` and `err` pulse together.
  - `plot` and `busy` stay 0, and the next request is granted normally.
- **Reset mid-draw:** assert `reset` at pixel 100.
  - The next cycle has all outputs at their reset values and state IDLE.
  - A following tie is granted to A.
- **Glyph pattern:** drive `glyph_on` = (u == v).
  - FG appears only at the 16 diagonal pixels of tile (9,6), with x 144..159 and y 96..111.
  - The max coordinates are (159,111) with no overflow.
